// File: rtl/axi_write_upsizer.sv
// AXI write-channel upsizer: packs UPSIZE_RATIO narrow slave slices into one wide master beat.
// The packed beat sits in a single output register; a ratio of 1 degenerates to wires.
module axi_write_upsizer #(
  parameter int C_AXI_ID_WIDTH         = 8,
  parameter int C_AXI_SLAVE_DATA_WIDTH = 128,
  parameter int UPSIZE_RATIO           = 2
) (
  input  logic                                               aclk,
  input  logic                                               areset,
  input  logic [C_AXI_ID_WIDTH-1:0]                          s_axi_wid,
  input  logic [C_AXI_SLAVE_DATA_WIDTH-1:0]                  s_axi_wdata,
  input  logic [C_AXI_SLAVE_DATA_WIDTH/8-1:0]                s_axi_wstrb,
  input  logic                                               s_axi_wlast,
  input  logic                                               s_axi_wvalid,
  output logic                                               s_axi_wready,
  output logic [C_AXI_ID_WIDTH-1:0]                          m_axi_wid,
  output logic [UPSIZE_RATIO*C_AXI_SLAVE_DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [UPSIZE_RATIO*C_AXI_SLAVE_DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                                               m_axi_wlast,
  output logic                                               m_axi_wvalid,
  input  logic                                               m_axi_wready
);

  localparam int SW = C_AXI_SLAVE_DATA_WIDTH;
  localparam int SB = SW / 8;
  localparam int R  = UPSIZE_RATIO;
  localparam int MW = R * SW;
  localparam int MB = R * SB;
  localparam int PW = (R > 1) ? $clog2(R) : 1;

  generate
    if (R == 1) begin : g_pass
      assign m_axi_wid    = s_axi_wid;
      assign m_axi_wdata  = s_axi_wdata;
      assign m_axi_wstrb  = s_axi_wstrb;
      assign m_axi_wlast  = s_axi_wlast;
      assign m_axi_wvalid = s_axi_wvalid;
      assign s_axi_wready = m_axi_wready;
    end else begin : g_pack
      localparam logic [PW-1:0] PTR_LAST = PW'(R - 1);

      logic [PW-1:0]             ptr_reg;
      logic [MW-1:0]             data_acc_reg;
      logic [MB-1:0]             strb_acc_reg;
      logic [C_AXI_ID_WIDTH-1:0] wid_acc_reg;
      logic [MW-1:0]             data_next;
      logic [MB-1:0]             strb_next;
      logic [C_AXI_ID_WIDTH-1:0] wid_next;
      logic                      m_valid_reg;
      logic                      m_last_reg;
      logic [MW-1:0]             m_data_reg;
      logic [MB-1:0]             m_strb_reg;
      logic [C_AXI_ID_WIDTH-1:0] m_wid_reg;
      logic                      accept;
      logic                      complete;

      // Ready only from the output register state, so a full register blocks intake.
      assign s_axi_wready = !m_valid_reg | m_axi_wready;
      assign accept       = s_axi_wvalid & s_axi_wready;
      assign complete     = accept & ((ptr_reg == PTR_LAST) | s_axi_wlast);
      assign wid_next     = (ptr_reg == '0) ? s_axi_wid : wid_acc_reg;

      // Beat as it would look with the current slice merged; slots above the pointer read as zero.
      for (genvar gi = 0; gi < R; gi++) begin : g_slot
        assign data_next[gi*SW +: SW] = (PW'(gi) == ptr_reg) ? s_axi_wdata
                                      : (PW'(gi) <  ptr_reg) ? data_acc_reg[gi*SW +: SW]
                                      : '0;
        assign strb_next[gi*SB +: SB] = (PW'(gi) == ptr_reg) ? s_axi_wstrb
                                      : (PW'(gi) <  ptr_reg) ? strb_acc_reg[gi*SB +: SB]
                                      : '0;
      end

      always_ff @(posedge aclk) begin
        if (areset) begin
          ptr_reg      <= '0;
          data_acc_reg <= '0;
          strb_acc_reg <= '0;
          wid_acc_reg  <= '0;
          m_valid_reg  <= 1'b0;
          m_last_reg   <= 1'b0;
          m_data_reg   <= '0;
          m_strb_reg   <= '0;
          m_wid_reg    <= '0;
        end else begin
          if (accept) begin
            if (complete) begin
              ptr_reg      <= '0;
              data_acc_reg <= '0;
              strb_acc_reg <= '0;
            end else begin
              ptr_reg      <= ptr_reg + 1'b1;
              data_acc_reg <= data_next;
              strb_acc_reg <= strb_next;
              wid_acc_reg  <= wid_next;
            end
          end
          // A completing slice is only accepted when the register is empty or draining.
          if (complete) begin
            m_valid_reg <= 1'b1;
            m_last_reg  <= s_axi_wlast;
            m_data_reg  <= data_next;
            m_strb_reg  <= strb_next;
            m_wid_reg   <= wid_next;
          end else if (m_axi_wready) begin
            m_valid_reg <= 1'b0;
          end
        end
      end

      assign m_axi_wvalid = m_valid_reg;
      assign m_axi_wlast  = m_last_reg;
      assign m_axi_wdata  = m_data_reg;
      assign m_axi_wstrb  = m_strb_reg;
      assign m_axi_wid    = m_wid_reg;
    end
  endgenerate

endmodule

// File: tb/tb_axi_write_upsizer.sv
// Directed bench for axi_write_upsizer: ratio-2 and ratio-4 packers plus a ratio-1 passthrough.
module tb_axi_write_upsizer;
  logic aclk = 1'b0;
  logic areset;
  always #5 aclk = ~aclk;

  int tests = 0;
  int fails = 0;

  // Ratio 2
  logic [7:0]   p2_swid;  logic [127:0] p2_sdata; logic [15:0] p2_sstrb;
  logic         p2_slast, p2_svalid, p2_sready;
  logic [7:0]   p2_mwid;  logic [255:0] p2_mdata; logic [31:0] p2_mstrb;
  logic         p2_mlast, p2_mvalid, p2_mready;
  // Ratio 4
  logic [7:0]   p4_swid;  logic [127:0] p4_sdata; logic [15:0] p4_sstrb;
  logic         p4_slast, p4_svalid, p4_sready;
  logic [7:0]   p4_mwid;  logic [511:0] p4_mdata; logic [63:0] p4_mstrb;
  logic         p4_mlast, p4_mvalid, p4_mready;
  // Ratio 1
  logic [7:0]   p1_swid;  logic [127:0] p1_sdata; logic [15:0] p1_sstrb;
  logic         p1_slast, p1_svalid, p1_sready;
  logic [7:0]   p1_mwid;  logic [127:0] p1_mdata; logic [15:0] p1_mstrb;
  logic         p1_mlast, p1_mvalid, p1_mready;

  axi_write_upsizer #(.C_AXI_ID_WIDTH(8), .C_AXI_SLAVE_DATA_WIDTH(128), .UPSIZE_RATIO(2)) dut2 (
    .aclk(aclk), .areset(areset),
    .s_axi_wid(p2_swid), .s_axi_wdata(p2_sdata), .s_axi_wstrb(p2_sstrb), .s_axi_wlast(p2_slast),
    .s_axi_wvalid(p2_svalid), .s_axi_wready(p2_sready),
    .m_axi_wid(p2_mwid), .m_axi_wdata(p2_mdata), .m_axi_wstrb(p2_mstrb), .m_axi_wlast(p2_mlast),
    .m_axi_wvalid(p2_mvalid), .m_axi_wready(p2_mready));

  axi_write_upsizer #(.C_AXI_ID_WIDTH(8), .C_AXI_SLAVE_DATA_WIDTH(128), .UPSIZE_RATIO(4)) dut4 (
    .aclk(aclk), .areset(areset),
    .s_axi_wid(p4_swid), .s_axi_wdata(p4_sdata), .s_axi_wstrb(p4_sstrb), .s_axi_wlast(p4_slast),
    .s_axi_wvalid(p4_svalid), .s_axi_wready(p4_sready),
    .m_axi_wid(p4_mwid), .m_axi_wdata(p4_mdata), .m_axi_wstrb(p4_mstrb), .m_axi_wlast(p4_mlast),
    .m_axi_wvalid(p4_mvalid), .m_axi_wready(p4_mready));

  axi_write_upsizer #(.C_AXI_ID_WIDTH(8), .C_AXI_SLAVE_DATA_WIDTH(128), .UPSIZE_RATIO(1)) dut1 (
    .aclk(aclk), .areset(areset),
    .s_axi_wid(p1_swid), .s_axi_wdata(p1_sdata), .s_axi_wstrb(p1_sstrb), .s_axi_wlast(p1_slast),
    .s_axi_wvalid(p1_svalid), .s_axi_wready(p1_sready),
    .m_axi_wid(p1_mwid), .m_axi_wdata(p1_mdata), .m_axi_wstrb(p1_mstrb), .m_axi_wlast(p1_mlast),
    .m_axi_wvalid(p1_mvalid), .m_axi_wready(p1_mready));

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  logic [127:0] a [4];
  logic [127:0] d [4];
  logic [127:0] c [4];
  logic [127:0] e0, e1, b0, x0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      a[i] = {4{32'(32'hA000_0000 + i)}};
      d[i] = {4{32'(32'hD000_0000 + i)}};
      c[i] = {4{32'(32'hC000_0000 + i)}};
    end
    e0 = {4{32'hE000_0000}};
    e1 = {4{32'hE111_1111}};
    b0 = {4{32'hB000_B000}};
    x0 = {4{32'h5555_AAAA}};

    p2_swid = '0; p2_sdata = '0; p2_sstrb = '0; p2_slast = 0; p2_svalid = 0; p2_mready = 1;
    p4_swid = '0; p4_sdata = '0; p4_sstrb = '0; p4_slast = 0; p4_svalid = 0; p4_mready = 1;
    p1_swid = '0; p1_sdata = '0; p1_sstrb = '0; p1_slast = 0; p1_svalid = 0; p1_mready = 0;
    areset = 1;
    tick;
    tick;
    chk("rst_r2_wvalid", p2_mvalid, 0);
    chk("rst_r2_wlast", p2_mlast, 0);
    chk("rst_r2_wid", p2_mwid, 0);
    chk("rst_r2_wdata", p2_mdata, 0);
    chk("rst_r2_wstrb", p2_mstrb, 0);
    chk("rst_r2_sready", p2_sready, 1);
    chk("rst_r4_wvalid", p4_mvalid, 0);
    chk("rst_r4_sready", p4_sready, 1);
    areset = 0;

    // Full burst, ratio 2
    p2_swid = 8'h11; p2_sstrb = 16'hFFFF; p2_svalid = 1;
    p2_sdata = a[0]; p2_slast = 0;
    tick;
    chk("full_b0_pending", p2_mvalid, 0);
    p2_sdata = a[1];
    tick;
    chk("full_b1_valid", p2_mvalid, 1);
    chk("full_b1_data", p2_mdata, {a[1], a[0]});
    chk("full_b1_strb", p2_mstrb, 32'hFFFF_FFFF);
    chk("full_b1_last", p2_mlast, 0);
    chk("full_b1_wid", p2_mwid, 8'h11);
    p2_sdata = a[2];
    tick;
    chk("full_b2_pending", p2_mvalid, 0);
    p2_sdata = a[3]; p2_slast = 1;
    tick;
    chk("full_b2_valid", p2_mvalid, 1);
    chk("full_b2_data", p2_mdata, {a[3], a[2]});
    chk("full_b2_last", p2_mlast, 1);
    p2_svalid = 0; p2_slast = 0;
    tick;
    chk("full_idle", p2_mvalid, 0);

    // Back-to-back single-slice beats: drain and load on the same edge
    p2_svalid = 1; p2_slast = 1; p2_sdata = e0; p2_sstrb = 16'h00F0; p2_swid = 8'h21;
    tick;
    chk("b2b_e0_valid", p2_mvalid, 1);
    chk("b2b_e0_data", p2_mdata, {128'h0, e0});
    chk("b2b_e0_strb", p2_mstrb, 32'h0000_00F0);
    p2_sdata = e1; p2_sstrb = 16'h0F00; p2_swid = 8'h22;
    tick;
    chk("b2b_e1_valid", p2_mvalid, 1);
    chk("b2b_e1_data", p2_mdata, {128'h0, e1});
    chk("b2b_e1_strb", p2_mstrb, 32'h0000_0F00);
    chk("b2b_e1_wid", p2_mwid, 8'h22);
    p2_svalid = 0; p2_slast = 0;
    tick;
    chk("b2b_idle", p2_mvalid, 0);

    // Backpressure, ratio 2: five edges with downstream not ready
    p2_mready = 0; p2_swid = 8'h33; p2_sstrb = 16'hFFFF; p2_svalid = 1; p2_sdata = d[0];
    #1;
    chk("bp_sready_empty", p2_sready, 1);
    tick;
    p2_sdata = d[1];
    tick;
    chk("bp_b1_valid", p2_mvalid, 1);
    chk("bp_b1_data", p2_mdata, {d[1], d[0]});
    chk("bp_sready_full", p2_sready, 0);
    p2_sdata = d[2];
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("bp_hold_valid", p2_mvalid, 1);
      chk("bp_hold_data", p2_mdata, {d[1], d[0]});
      chk("bp_hold_sready", p2_sready, 0);
    end
    p2_mready = 1;
    #1;
    chk("bp_release_sready", p2_sready, 1);
    chk("bp_release_data", p2_mdata, {d[1], d[0]});
    tick;
    chk("bp_after_drain", p2_mvalid, 0);
    p2_sdata = d[3]; p2_slast = 1;
    tick;
    chk("bp_b2_valid", p2_mvalid, 1);
    chk("bp_b2_data", p2_mdata, {d[3], d[2]});
    chk("bp_b2_last", p2_mlast, 1);
    p2_svalid = 0; p2_slast = 0;
    tick;
    chk("bp_idle", p2_mvalid, 0);

    // Early wlast, ratio 4
    p4_swid = 8'h44; p4_sdata = b0; p4_sstrb = 16'h00FF; p4_slast = 1; p4_svalid = 1;
    tick;
    chk("early_valid", p4_mvalid, 1);
    chk("early_data", p4_mdata, {384'h0, b0});
    chk("early_strb", p4_mstrb, 64'h0000_0000_0000_00FF);
    chk("early_last", p4_mlast, 1);
    chk("early_wid", p4_mwid, 8'h44);
    p4_svalid = 0; p4_slast = 0;
    tick;
    chk("early_idle", p4_mvalid, 0);

    // Reset mid-beat, ratio 4
    p4_swid = 8'h66; p4_sdata = x0; p4_sstrb = 16'hFFFF; p4_svalid = 1;
    tick;
    tick;
    chk("rmid_partial", p4_mvalid, 0);
    p4_svalid = 0; areset = 1;
    tick;
    chk("rmid_rst_valid", p4_mvalid, 0);
    chk("rmid_rst_sready", p4_sready, 1);
    areset = 0;
    p4_swid = 8'h55; p4_sstrb = 16'h0001; p4_svalid = 1;
    for (int i = 0; i < 4; i++) begin
      p4_sdata = c[i]; p4_slast = (i == 3);
      tick;
      if (i < 3) chk("rmid_pending", p4_mvalid, 0);
    end
    chk("rmid_valid", p4_mvalid, 1);
    chk("rmid_data", p4_mdata, {c[3], c[2], c[1], c[0]});
    chk("rmid_strb", p4_mstrb, {4{16'h0001}});
    chk("rmid_last", p4_mlast, 1);
    chk("rmid_wid", p4_mwid, 8'h55);
    p4_svalid = 0; p4_slast = 0;
    tick;
    chk("rmid_idle", p4_mvalid, 0);

    // Passthrough, ratio 1
    for (int i = 0; i < 8; i++) begin
      p1_swid   = 8'($urandom);
      p1_sdata  = {$urandom, $urandom, $urandom, $urandom};
      p1_sstrb  = 16'($urandom);
      p1_slast  = 1'($urandom);
      p1_svalid = 1'($urandom);
      p1_mready = 1'($urandom);
      #1;
      chk("pass_wid", p1_mwid, p1_swid);
      chk("pass_data", p1_mdata, p1_sdata);
      chk("pass_strb", p1_mstrb, p1_sstrb);
      chk("pass_last", p1_mlast, p1_slast);
      chk("pass_valid", p1_mvalid, p1_svalid);
      chk("pass_sready", p1_sready, p1_mready);
      tick;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/axi_write_upsizer.md
AXI_WRITE_UPSIZER -- requirements
Module: axi_write_upsizer

Interface
REQ-001 SHALL have parameter C_AXI_ID_WIDTH, default 8, giving the width of the write ID.
REQ-002 SHALL have parameter C_AXI_SLAVE_DATA_WIDTH, default 128, giving the narrow slave-port data width.
REQ-003 SHALL have parameter UPSIZE_RATIO, default 2, where master data width = UPSIZE_RATIO*C_AXI_SLAVE_DATA_WIDTH; legal values are 1, 2, 4 and 8.
REQ-004 SHALL use one clock and a synchronous, active-high reset, with ports as follows:
  aclk            in   1      clock; all logic on the rising edge
  areset          in   1      synchronous active-high reset
  s_axi_wid       in   ID     slave write ID
  s_axi_wdata     in   SW     narrow write data (SW = C_AXI_SLAVE_DATA_WIDTH)
  s_axi_wstrb     in   SW/8   narrow byte strobes
  s_axi_wlast     in   1      last slice of the burst
  s_axi_wvalid    in   1      slave beat valid
  s_axi_wready    out  1      slave beat accepted
  m_axi_wid       out  ID     master write ID
  m_axi_wdata     out  R*SW   wide write data
  m_axi_wstrb     out  R*SW/8 wide byte strobes
  m_axi_wlast     out  1      last wide beat of the burst
  m_axi_wvalid    out  1      wide beat valid
  m_axi_wready    in   1      downstream ready

Function
REQ-005 SHALL pack consecutive accepted slave slices into one wide beat, least-significant slot first: slot k occupies data bits [k*SW +: SW] and strobe bits [k*SW/8 +: SW/8].
REQ-006 SHALL keep a slot pointer of width max(1,log2 R); the pointer is 0 at reset and at every burst start, increments on each accepted slice, and wraps R-1 -> 0.
REQ-007 SHALL treat a beat as complete when a slice is accepted with pointer == R-1 or with s_axi_wlast = 1, whichever occurs first.
REQ-008 SHALL, on an early wlast (pointer < R-1), force all unfilled higher slots to data 0 and strobe 0.
REQ-009 SHALL load a completed beat into a single output register; m_axi_wvalid SHALL rise in the cycle after the completing slice is accepted (latency 1 cycle).
REQ-010 SHALL set m_axi_wlast = 1 only for the beat completed by a slice with s_axi_wlast = 1.
REQ-011 SHALL take m_axi_wid from slot 0's s_axi_wid; wid SHALL be constant within a wide beat (a mid-beat change is a protocol violation and its behaviour is undefined).
REQ-012 SHALL drive s_axi_wready = !m_axi_wvalid | m_axi_wready, with no dependence on s_axi_wvalid.
REQ-013 SHALL sustain one slave slice per cycle while m_axi_wready is held high: one accepted slice per cycle and one wide beat every R cycles.
REQ-014 SHALL hold m_axi_wvalid, wdata, wstrb, wid and wlast stable until m_axi_wready = 1 (AXI stability rule).
REQ-015 SHALL, on a simultaneous drain of the output beat and completion of a new beat, load the new beat in the same cycle, leaving no bubble.
REQ-016 SHALL clear the slot pointer and slot strobes once a beat completes, so stale strobes never reach the next beat.
REQ-017 SHALL, when UPSIZE_RATIO == 1, reduce to pure wires: m_* = s_*, s_axi_wready = m_axi_wready, with no registers.
REQ-018 SHALL start every burst at slot 0; unaligned start addresses are out of scope.

Reset
REQ-019 SHALL, while areset = 1, drive m_axi_wvalid = 0, m_axi_wlast = 0, m_axi_wid = 0, m_axi_wdata = 0, m_axi_wstrb = 0, pointer = 0, and slot data/strobes = 0.
REQ-020 SHALL discard any partially packed beat or pending output beat when areset is asserted mid-burst; the first slice after reset SHALL go to slot 0.
REQ-021 SHALL keep s_axi_wready = 1 during and after reset, since the output register is empty.

Verification
REQ-022 Full burst, R=2, SW=128, m_axi_wready=1: 4 slices, data A0..A3, strb all-ones, wlast on A3 -> 2 wide beats {A1,A0} and {A3,A2}; strb all-ones; wlast only on the 2nd beat; each beat valid 1 cycle after its completing slice.
REQ-023 Early wlast, R=4: 1 slice B0 with strb 0x00FF and wlast=1 -> one beat, data {0,0,0,B0}, strb 0x0000_0000_0000_00FF, wlast=1.
REQ-024 Backpressure, R=2: m_axi_wready=0 for 5 cycles while 4 slices are offered -> s_axi_wready drops after beat 1 completes; no data lost; outputs stable; both beats delivered in order once ready=1.
REQ-025 Reset mid-beat, R=4: accept 2 slices, assert areset for 1 cycle, then send 4 slices C0..C3 with wlast on C3 -> exactly one beat {C3,C2,C1,C0}; no stale strobes.
REQ-026 Passthrough, R=1: random valid/ready/data -> master outputs equal slave inputs in the same cycle, and s_axi_wready == m_axi_wready.
